// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice.
// Contents:
// - the default datapath width
// - the opcode constants decoded by alu_core
// - the FSM state encoding. The arbiter exposes this encoding on its debug port.
package alu_arbiter_pkg;

  localparam int ALU_WIDTH_DEFAULT = 8;

  // Opcodes 3'b100..3'b111 are reserved and flag an error.
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// alu_core
// Purely combinational ALU shared by both requesters.
// Ports:
//   op     in  3      opcode (see alu_arbiter_pkg)
//   a, b   in  WIDTH  operands
//   result out WIDTH  FWD: b, ADD: a+b (carry dropped), AND, OR; reserved: 0
//   err    out 1      opcode was reserved
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      ALU_FWD: result = b;
      // Same-width add: the carry is discarded, so signed operands wrap.
      ALU_ADD: result = a + b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter that lets two requesters share a single ALU.
// The arbiter accepts one operation at a time. It executes the operation in one
// registered cycle. It then holds the tagged result until the consumer takes it.
//
// Handshake rules:
// - A transfer happens on a rising edge where VALID and READY are both 1.
// - A source holds VALID and its payload until READY.
// - REQn_READY is combinational. It is only ever high in IDLE, and only for one
//   requester at a time.
// - RESP_VALID stays high with RESULT/RESP_ID/RESP_ERR stable until RESP_READY.
//
// Ports:
//   CLK, RESET              clock; asynchronous active-high reset
//   REQn_VALID/OP/A/B       requester n operation (n = 0, 1)
//   REQn_READY              requester n operation accepted this cycle
//   RESP_VALID, RESP_READY  response handshake
//   RESP_ID, RESULT, RESP_ERR  issuing requester, ALU result, reserved-opcode flag
//   DBG_STATE               current FSM state (debug observation only)
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0_VALID,
  input  logic [2:0]       REQ0_OP,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  output logic             REQ0_READY,
  input  logic             REQ1_VALID,
  input  logic [2:0]       REQ1_OP,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  output logic             REQ1_READY,
  output logic             RESP_VALID,
  input  logic             RESP_READY,
  output logic             RESP_ID,
  output logic [WIDTH-1:0] RESULT,
  output logic             RESP_ERR,
  output state_t           DBG_STATE
);

  state_t           state;
  logic             last_grant;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] alu_result;
  logic             alu_err;

  // Tie-break favours the requester that was not served last.
  // last_grant resets to 1, so requester 0 wins the first tie after reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == ST_IDLE && !RESET) begin
      if (REQ0_VALID && (!REQ1_VALID || last_grant)) grant0 = 1'b1;
      else if (REQ1_VALID)                           grant1 = 1'b1;
    end
  end

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;
  assign DBG_STATE  = state;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .err    (alu_err)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      RESP_VALID <= 1'b0;
      RESP_ID    <= 1'b0;
      RESULT     <= '0;
      RESP_ERR   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0) begin
            op_q  <= REQ0_OP;
            a_q   <= REQ0_A;
            b_q   <= REQ0_B;
            id_q  <= 1'b0;
            state <= ST_EXEC;
          end else if (grant1) begin
            op_q  <= REQ1_OP;
            a_q   <= REQ1_A;
            b_q   <= REQ1_B;
            id_q  <= 1'b1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          RESULT     <= alu_result;
          RESP_ERR   <= alu_err;
          RESP_ID    <= id_q;
          RESP_VALID <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (RESP_READY) begin
            RESP_VALID <= 1'b0;
            last_grant <= RESP_ID;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
